alien_multi_shot_ctrl: RTL and testbench
========================================

Name: alien_multi_shot_ctrl

Overview:
- Parametrised successor to the single alien-shot block.
- Manages up to NUM_SHOTS concurrent alien shots, each with its own position and alive flag.
- An LFSR-randomised per-frame cooldown schedules spawns; shots move at a configurable speed and are killed per slot on collision or when they leave the screen.
- Sits between the alien matrix (muzzle position), the collision detector and the video mux; produces one merged drawing request and RGB.

Parameters:
- NUM_SHOTS, 4: number of independent shot slots (1..8).
- SHOT_W, 2: shot width in pixels.
- SHOT_H, 16: shot height in pixels.
- SPEED, 4: downward pixels moved per frame.
- SCREEN_H, 480: a shot dies once its top Y is at or beyond this value.
- MIN_GAP, 16: minimum frames between spawns (≥1).
- RAND_MASK, 31: mask applied to the LFSR to form the extra random gap; 0 gives a fixed interval.
- LFSR_SEED, 10'h2A5: LFSR reset value (nonzero).
- SHOT_COLOR, 8'hFF: RGB of a drawn shot.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- playGame  in  1  high while in a game level
- alienFireCollision  in  1  collision of the shot pixel drawn in the previous cycle
- alienXPosition  in  11  spawn X (muzzle of the selected bottom alien)
- alienYPosition  in  11  spawn Y
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- alienShotDR  out  1  drawing request, registered
- alienShotRGB  out  8  shot colour, registered
- shotsAlive  out  NUM_SHOTS  per-slot alive flags

Behaviour:
- Clock and reset: one clock, clk. resetN is synchronous and active-low.
- Reset values:
  - all slots dead, x=0, y=0;
  - shotsAlive=0, alienShotDR=0, alienShotRGB=8'h00;
  - cooldown=MIN_GAP, lfsr=LFSR_SEED, hitIdx=0.
- LFSR:
  - 10-bit Fibonacci, taps x^10+x^7+1.
  - Advances every clock, regardless of playGame.
- playGame low: synchronously clears every alive flag and holds cooldown=MIN_GAP; no spawns occur.
- On startOfFrame with playGame high, in a single update:
  - Move: each alive slot gets y <= y + SPEED (11-bit, no wrap possible for SCREEN_H ≤ 1023). If y + SPEED ≥ SCREEN_H, the slot dies instead.
  - Cooldown: if cooldown > 0, it decrements.
  - Spawn: if cooldown == 0 and a free slot exists, the lowest-index free slot loads x=alienXPosition and y=alienYPosition and goes alive (not moved this frame). Cooldown then reloads to MIN_GAP + (lfsr & RAND_MASK).
  - No free slot: cooldown holds at 0 and a spawn occurs on the first frame a slot is free.
  - Freed and spawned in the same frame: a slot freed by the move in this frame is not reusable until the next frame.
- Drawing:
  - Slot i hits when alive, x_i ≤ pixelX < x_i+SHOT_W and y_i ≤ pixelY < y_i+SHOT_H.
  - alienShotDR <= OR of hits. alienShotRGB <= SHOT_COLOR if any hit, else 8'h00.
  - hitIdx <= lowest hitting index, captured only when a hit exists.
  - Latency: 1 clock.
- Collision:
  - alienFireCollision high while alienShotDR is high kills slot hitIdx at the next edge.
  - alienFireCollision while alienShotDR is low is ignored.
- Priority per slot:
  1. reset;
  2. playGame low clear;
  3. collision kill;
  4. move or bottom kill;
  5. spawn.
  - A collision coincident with startOfFrame on the same slot kills it; the move is discarded.
- shotsAlive is a direct copy of the alive flags; new values appear the cycle after the updating edge.

Test Plan:
- Reset: hold resetN=0 for 3 clocks, then release with playGame=1 and RAND_MASK=0, MIN_GAP=2 → shotsAlive=0. After the 2nd startOfFrame, cooldown=0; the spawn occurs on the 3rd startOfFrame with slot0 at the alien position.
- Motion and bottom kill: spawn at y=460, SPEED=4 → y goes 464, 468, 472, 476; on the next frame 480 ≥ SCREEN_H, so slot0 dies and shotsAlive[0]=0.
- Drawing: slot0 at (100,200). Scan pixel (101,215) → alienShotDR=1 and RGB=8'hFF one clock later. Pixel (102,215) or (101,216) → DR=0 and RGB=8'h00.
- Collision: slot1 drawn and alienFireCollision=1 on the DR cycle → only shotsAlive[1] clears next edge. Collision with DR=0 → no change.
- Saturation: MIN_GAP=1, RAND_MASK=0, NUM_SHOTS=4 → after 4 spawns shotsAlive=4'b1111 and no 5th spawn. Kill slot2 → slot2 respawns on the next startOfFrame.
- playGame drop mid-flight with 3 slots alive → all clear next edge. Cooldown reads MIN_GAP. No spawn until playGame=1 and MIN_GAP frames elapse.

Source files
------------

// File: rtl/alien_multi_shot_ctrl.sv
// alien_multi_shot_ctrl: NUM_SHOTS alien shot slots with LFSR-randomised spawn cooldown,
// per-slot motion, bottom/collision kill and a merged registered drawing request.
module alien_multi_shot_ctrl #(
  parameter int NUM_SHOTS = 4,
  parameter int SHOT_W = 2,
  parameter int SHOT_H = 16,
  parameter int SPEED = 4,
  parameter int SCREEN_H = 480,
  parameter int MIN_GAP = 16,
  parameter int RAND_MASK = 31,
  parameter logic [9:0] LFSR_SEED = 10'h2A5,
  parameter logic [7:0] SHOT_COLOR = 8'hFF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 playGame,
  input  logic                 alienFireCollision,
  input  logic [10:0]          alienXPosition,
  input  logic [10:0]          alienYPosition,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  output logic                 alienShotDR,
  output logic [7:0]           alienShotRGB,
  output logic [NUM_SHOTS-1:0] shotsAlive
);
  localparam int IW = NUM_SHOTS > 1 ? $clog2(NUM_SHOTS) : 1;
  localparam int CW = 16;
  logic [10:0] r_x [NUM_SHOTS];
  logic [10:0] r_y [NUM_SHOTS];
  logic [NUM_SHOTS-1:0] r_alive, w_hit;
  logic [9:0] r_lfsr;
  logic [CW-1:0] r_cool;
  logic [IW-1:0] r_hit_idx, w_hit_idx, w_free_idx;
  logic w_free, w_spawn, w_kill;
  // Descending scan so the lowest index wins for both the free slot and the hit slot.
  always_comb begin
    w_hit = '0;
    w_free = 1'b0;
    w_free_idx = '0;
    w_hit_idx = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      w_hit[i] = r_alive[i] && pixelX >= r_x[i] && {1'b0, pixelX} < {1'b0, r_x[i]} + 12'(SHOT_W)
                 && pixelY >= r_y[i] && {1'b0, pixelY} < {1'b0, r_y[i]} + 12'(SHOT_H);
      if (!r_alive[i]) begin
        w_free = 1'b1;
        w_free_idx = IW'(i);
      end
      if (w_hit[i]) w_hit_idx = IW'(i);
    end
    w_kill = alienFireCollision && alienShotDR && r_alive[r_hit_idx];
    w_spawn = startOfFrame && playGame && r_cool == '0 && w_free;
  end
  always_ff @(posedge clk) begin
    r_lfsr <= !resetN ? LFSR_SEED : {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    if (!resetN) begin
      r_alive <= '0;
      r_cool <= CW'(MIN_GAP);
      r_hit_idx <= '0;
      alienShotDR <= 1'b0;
      alienShotRGB <= 8'h00;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      alienShotDR <= |w_hit;
      alienShotRGB <= |w_hit ? SHOT_COLOR : 8'h00;
      if (|w_hit) r_hit_idx <= w_hit_idx;
      if (!playGame) begin
        r_alive <= '0;
        r_cool <= CW'(MIN_GAP);
      end else begin
        if (startOfFrame)
          r_cool <= r_cool != '0 ? r_cool - 1'b1
                  : w_free ? CW'(MIN_GAP) + CW'(r_lfsr & 10'(RAND_MASK)) : r_cool;
        // Free-slot choice uses pre-move flags, so a slot freed by this frame's move waits a frame.
        for (int i = 0; i < NUM_SHOTS; i++) begin
          if (w_kill && r_hit_idx == IW'(i)) r_alive[i] <= 1'b0;
          else if (startOfFrame && r_alive[i]) begin
            if ({1'b0, r_y[i]} + 12'(SPEED) >= 12'(SCREEN_H)) r_alive[i] <= 1'b0;
            else r_y[i] <= r_y[i] + 11'(SPEED);
          end else if (w_spawn && w_free_idx == IW'(i)) begin
            r_alive[i] <= 1'b1;
            r_x[i] <= alienXPosition;
            r_y[i] <= alienYPosition;
          end
        end
      end
    end
  end
  assign shotsAlive = r_alive;
endmodule

// File: tb/tb_alien_multi_shot_ctrl.sv
// tb_alien_multi_shot_ctrl: directed vectors for spawn timing, motion, drawing,
// collision, saturation and playGame clear with MIN_GAP=2 and a fixed interval.
module tb_alien_multi_shot_ctrl;
  typedef struct packed {
    logic [10:0] px;
    logic [10:0] py;
    logic        dr;
    logic [7:0]  rgb;
  } vec_t;
  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, play = 1'b0, coll = 1'b0;
  logic [10:0] ax = '0, ay = '0, px = '0, py = '0;
  logic dr;
  logic [7:0] rgb;
  logic [3:0] alive;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl [7];
  alien_multi_shot_ctrl #(.MIN_GAP(2), .RAND_MASK(0)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(play),
    .alienFireCollision(coll), .alienXPosition(ax), .alienYPosition(ay),
    .pixelX(px), .pixelY(py), .alienShotDR(dr), .alienShotRGB(rgb), .shotsAlive(alive)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic frame();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask
  task automatic draw(input string nm, input int x, input int y, input logic e);
    px = 11'(x);
    py = 11'(y);
    @(negedge clk);
    chk({nm, "_dr"}, {31'd0, dr}, {31'd0, e});
    chk({nm, "_rgb"}, {24'd0, rgb}, e ? 32'hFF : 32'h00);
  endtask
  initial begin
    tbl[0] = '{11'd101, 11'd215, 1'b1, 8'hFF};
    tbl[1] = '{11'd102, 11'd215, 1'b0, 8'h00};
    tbl[2] = '{11'd101, 11'd216, 1'b0, 8'h00};
    tbl[3] = '{11'd100, 11'd200, 1'b1, 8'hFF};
    tbl[4] = '{11'd99,  11'd200, 1'b0, 8'h00};
    tbl[5] = '{11'd100, 11'd199, 1'b0, 8'h00};
    tbl[6] = '{11'd101, 11'd200, 1'b1, 8'hFF};
    repeat (3) @(negedge clk);
    chk("rst_alive", {28'd0, alive}, 32'h0);
    chk("rst_dr", {31'd0, dr}, 32'h0);
    chk("rst_rgb", {24'd0, rgb}, 32'h0);
    resetN = 1'b1;
    play = 1'b1;
    ax = 11'd100;
    ay = 11'd200;
    @(negedge clk);
    chk("post_rst_alive", {28'd0, alive}, 32'h0);
    frame();
    chk("f1_alive", {28'd0, alive}, 32'h0);
    frame();
    chk("f2_alive", {28'd0, alive}, 32'h0);
    frame();
    chk("f3_spawn", {28'd0, alive}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      px = tbl[i].px;
      py = tbl[i].py;
      @(negedge clk);
      chk($sformatf("tbl%0d_dr", i), {31'd0, dr}, {31'd0, tbl[i].dr});
      chk($sformatf("tbl%0d_rgb", i), {24'd0, rgb}, {24'd0, tbl[i].rgb});
    end
    frame();
    frame();
    ax = 11'd300;
    ay = 11'd100;
    frame();
    chk("f6_spawn1", {28'd0, alive}, 32'h3);
    draw("slot1", 300, 100, 1'b1);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    chk("coll_kill1", {28'd0, alive}, 32'h1);
    draw("slot0_at212", 100, 212, 1'b1);
    draw("off", 0, 0, 1'b0);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    chk("coll_no_dr", {28'd0, alive}, 32'h1);
    ax = 11'd50;
    ay = 11'd460;
    frame();
    frame();
    frame();
    chk("f9_spawn1", {28'd0, alive}, 32'h3);
    draw("slot1_460", 50, 460, 1'b1);
    ax = 11'd600;
    ay = 11'd0;
    frame();
    frame();
    frame();
    frame();
    chk("f13_alive", {28'd0, alive}, 32'h7);
    draw("slot1_476", 50, 476, 1'b1);
    draw("slot1_475", 50, 475, 1'b0);
    frame();
    chk("f14_bottom", {28'd0, alive}, 32'h5);
    frame();
    chk("f15_spawn1", {28'd0, alive}, 32'h7);
    frame();
    frame();
    frame();
    chk("f18_spawn3", {28'd0, alive}, 32'hF);
    frame();
    frame();
    frame();
    chk("f21_full", {28'd0, alive}, 32'hF);
    draw("slot2", 600, 45, 1'b1);
    coll = 1'b1;
    @(negedge clk);
    coll = 1'b0;
    chk("coll_kill2", {28'd0, alive}, 32'hB);
    px = '0;
    py = '0;
    ax = 11'd700;
    ay = 11'd300;
    frame();
    chk("f22_respawn2", {28'd0, alive}, 32'hF);
    draw("slot2_new", 700, 300, 1'b1);
    play = 1'b0;
    @(negedge clk);
    chk("play_clear", {28'd0, alive}, 32'h0);
    frame();
    chk("play_low_frame", {28'd0, alive}, 32'h0);
    play = 1'b1;
    frame();
    chk("resume_f1", {28'd0, alive}, 32'h0);
    frame();
    chk("resume_f2", {28'd0, alive}, 32'h0);
    frame();
    chk("resume_f3", {28'd0, alive}, 32'h1);
    draw("resume_slot0", 700, 300, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
